// File: rtl/trigger_sequencer.sv
// trigger_sequencer: multi-stage trigger engine for the logic analyzer capture path.
// Walks a programmable sequence of pattern/edge stages (each with an occurrence
// count) and then runs a counted post-trigger window.
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_data                   sampled channel word
//   i_cfg_*                  stage configuration write port (accepted in IDLE/DONE)
//   i_num_stages             index of the last active stage
//   i_post_count             run-window length (0 = unbounded)
//   i_arm, i_once            arm (rising edge), single-shot vs auto re-arm
//   i_ext_trig, i_ext_enable external trigger (rising edge) and its gate
//   i_man_toggle             manual start/stop (rising edge)
//   o_state, o_stage         current state and stage index
//   o_trig, o_run, o_cfg_err trigger pulse, run window, rejected-write pulse
module trigger_sequencer #(
  parameter  int WIDTH  = 8,
  parameter  int STAGES = 4,
  parameter  int CNT_W  = 16,
  localparam int SW     = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_cfg_we,
  input  logic [SW-1:0]    i_cfg_stage,
  input  logic [WIDTH-1:0] i_cfg_mask,
  input  logic [WIDTH-1:0] i_cfg_value,
  input  logic [WIDTH-1:0] i_cfg_rise,
  input  logic [WIDTH-1:0] i_cfg_fall,
  input  logic [CNT_W-1:0] i_cfg_count,
  input  logic [SW-1:0]    i_num_stages,
  input  logic [CNT_W-1:0] i_post_count,
  input  logic             i_arm,
  input  logic             i_once,
  input  logic             i_ext_trig,
  input  logic             i_ext_enable,
  input  logic             i_man_toggle,
  output logic [1:0]       o_state,
  output logic [SW-1:0]    o_stage,
  output logic             o_trig,
  output logic             o_run,
  output logic             o_cfg_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CNT_W-1:0] post_q, post_d;
  logic             trig_q, trig_d;
  logic             run_q, run_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] d_prev_q;
  logic             valid_q;
  logic             arm_q, man_q, ext_q;

  logic [WIDTH-1:0] mask_q  [STAGES];
  logic [WIDTH-1:0] value_q [STAGES];
  logic [WIDTH-1:0] rise_q  [STAGES];
  logic [WIDTH-1:0] fall_q  [STAGES];
  logic [CNT_W-1:0] count_q [STAGES];

  logic             cfg_open;
  logic             arm_ev, man_ev, ext_ev;
  logic [WIDTH-1:0] cur_mask, cur_value, cur_rise, cur_fall;
  logic [CNT_W-1:0] cur_count;
  logic             level_ok, edge_ok, hit;
  logic             num_ok;
  logic [SW-1:0]    last_stage;
  logic             go_run;

  assign cfg_open = (state_q == IDLE) || (state_q == DONE);
  assign arm_ev   = i_arm & ~arm_q;
  assign man_ev   = i_man_toggle & ~man_q;
  assign ext_ev   = i_ext_trig & ~ext_q & i_ext_enable;

  // Stage lookup and last-stage clamp use index-compare loops so that
  // out-of-range indices (non power-of-two STAGES) never address the arrays.
  always_comb begin
    cur_mask  = '0;
    cur_value = '0;
    cur_rise  = '0;
    cur_fall  = '0;
    cur_count = '0;
    num_ok    = 1'b0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (stage_q == SW'(i)) begin
        cur_mask  = mask_q[i];
        cur_value = value_q[i];
        cur_rise  = rise_q[i];
        cur_fall  = fall_q[i];
        cur_count = count_q[i];
      end
      if (i_num_stages == SW'(i)) num_ok = 1'b1;
    end
    last_stage = num_ok ? i_num_stages : SW'(STAGES - 1);
  end

  always_comb begin
    level_ok = (((i_data ^ cur_value) & cur_mask) == '0);
    if ((cur_rise == '0) && (cur_fall == '0)) begin
      edge_ok = 1'b1;
    end else begin
      edge_ok = valid_q & ((|(cur_rise & i_data & ~d_prev_q)) |
                           (|(cur_fall & ~i_data & d_prev_q)));
    end
    hit = level_ok & edge_ok;
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    hit_d   = hit_q;
    post_d  = post_q;
    trig_d  = 1'b0;
    go_run  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (man_ev) begin
          go_run = 1'b1;
        end else if (arm_ev) begin
          state_d = ARMED;
          stage_d = '0;
          hit_d   = '0;
        end
      end
      ARMED: begin
        if (man_ev || ext_ev) begin
          go_run = 1'b1;
        end else if (hit) begin
          if (hit_q == cur_count) begin
            if (stage_q >= last_stage) begin
              go_run = 1'b1;
            end else begin
              stage_d = stage_q + 1'b1;
              hit_d   = '0;
            end
          end else if (hit_q != '1) begin
            hit_d = hit_q + 1'b1;
          end
        end
      end
      RUN: begin
        if (man_ev || ((i_post_count != '0) && (post_q == i_post_count - 1'b1))) begin
          state_d = DONE;
        end else if (post_q != '1) begin
          post_d = post_q + 1'b1;
        end
      end
      DONE: begin
        if (man_ev) begin
          go_run = 1'b1;
        end else if (!i_once || arm_ev) begin
          state_d = ARMED;
          stage_d = '0;
          hit_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (go_run) begin
      state_d = RUN;
      post_d  = '0;
      trig_d  = 1'b1;
    end
    run_d = (state_d == RUN);
    err_d = i_cfg_we & ~cfg_open;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      stage_q  <= '0;
      hit_q    <= '0;
      post_q   <= '0;
      trig_q   <= 1'b0;
      run_q    <= 1'b0;
      err_q    <= 1'b0;
      d_prev_q <= '0;
      valid_q  <= 1'b0;
      arm_q    <= 1'b0;
      man_q    <= 1'b0;
      ext_q    <= 1'b0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        mask_q[i]  <= '0;
        value_q[i] <= '0;
        rise_q[i]  <= '0;
        fall_q[i]  <= '0;
        count_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      hit_q    <= hit_d;
      post_q   <= post_d;
      trig_q   <= trig_d;
      run_q    <= run_d;
      err_q    <= err_d;
      d_prev_q <= i_data;
      valid_q  <= 1'b1;
      arm_q    <= i_arm;
      man_q    <= i_man_toggle;
      ext_q    <= i_ext_trig;
      for (int unsigned i = 0; i < STAGES; i++) begin
        if (i_cfg_we && cfg_open && (i_cfg_stage == SW'(i))) begin
          mask_q[i]  <= i_cfg_mask;
          value_q[i] <= i_cfg_value;
          rise_q[i]  <= i_cfg_rise;
          fall_q[i]  <= i_cfg_fall;
          count_q[i] <= i_cfg_count;
        end
      end
    end
  end

  assign o_state   = state_q;
  assign o_stage   = stage_q;
  assign o_trig    = trig_q;
  assign o_run     = run_q;
  assign o_cfg_err = err_q;

endmodule
